// File: rtl/gpr_file_sb.sv
// gpr_file_sb: MIPS register file, NREAD bypassed read ports, writeback port A (with jal link), long-latency port B, busy scoreboard
//   CLK, reset (sync, active-high): clock and reset of all registers, busy bits and wr_conflict
//   wa_*: in-order writeback port; wa_link redirects the write to LINK_REG; wa_pc is trace only
//   wb_*: long-latency return port; wb_en also clears the busy bit of wb_addr; wb_pc is trace only
//   iss_en/iss_addr: long-latency issue, marks the destination busy
//   rd_addr/rd_data/rd_busy: packed read ports, port k at [k*W +: W], bypassed from both write ports
//   busy_vec: raw scoreboard; wr_conflict: one-cycle pulse after A and B wrote the same register
//   RF_TRACE_EN: when defined, prints every committed write
module gpr_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD = 2,
  parameter int LINK_REG = 31
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     wa_en,
  input  logic                     wa_link,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic [31:0]              wa_pc,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [31:0]              wb_pc,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_busy,
  output logic [(1<<ADDR_W)-1:0]   busy_vec,
  output logic                     wr_conflict
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [ADDR_W-1:0] ea;
  logic wa_ok, wb_ok, conflict;
  assign ea = wa_link ? LINK_A : wa_addr;
  assign wa_ok = wa_en && ea != '0;
  assign wb_ok = wb_en && wb_addr != '0;
  assign conflict = wa_ok && wb_ok && ea == wb_addr;
  assign busy_vec = busy;
  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_addr] = 1'b0;
    if (iss_en && iss_addr != '0) busy_nxt[iss_addr] = 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      busy <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (wb_ok && !conflict) rf[wb_addr] <= wb_data;
      if (wa_ok) rf[ea] <= wa_data;
      busy <= busy_nxt;
      wr_conflict <= conflict;
    end
  end
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic wb_hit;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign wb_hit = wb_en && wb_addr == a;
    assign rd_data[k*DATA_W +: DATA_W] = a == '0 ? '0 : (wa_en && ea == a) ? wa_data : wb_hit ? wb_data : rf[a];
    assign rd_busy[k] = a != '0 && busy[a] && !wb_hit;
  end
`ifdef RF_TRACE_EN
  always_ff @(posedge CLK) begin
    if (!reset && wa_ok) $display("@%h: $%0d <= %h", wa_pc, ea, wa_data);
    if (!reset && wb_ok && !conflict) $display("@%h: $%0d <= %h", wb_pc, wb_addr, wb_data);
  end
`else
  logic unused_pc;
  assign unused_pc = ^{wa_pc, wb_pc};
`endif
endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed self-checking bench for gpr_file_sb
module tb_gpr_file_sb;
  logic CLK = 1'b0;
  logic reset;
  logic wa_en, wa_link, wb_en, iss_en;
  logic [4:0] wa_addr, wb_addr, iss_addr;
  logic [31:0] wa_data, wa_pc, wb_data, wb_pc;
  logic [9:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic [31:0] busy_vec;
  logic wr_conflict;
  int vectors = 0;
  int miscompares = 0;
  always #5 CLK = ~CLK;
  gpr_file_sb dut (
    .CLK(CLK), .reset(reset),
    .wa_en(wa_en), .wa_link(wa_link), .wa_addr(wa_addr), .wa_data(wa_data), .wa_pc(wa_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .busy_vec(busy_vec), .wr_conflict(wr_conflict)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle();
    wa_en = 0; wa_link = 0; wb_en = 0; iss_en = 0; reset = 0;
  endtask
  initial begin
    idle();
    wa_addr = 0; wb_addr = 0; iss_addr = 0; wa_data = 0; wb_data = 0;
    wa_pc = 32'h400; wb_pc = 32'h800; rd_addr = 0;
    reset = 1;
    tick();
    reset = 0;
    rd_addr = {5'd8, 5'd1};
    #1;
    check("rst_busy", busy_vec, 0);
    check("rst_conf", wr_conflict, 0);
    check("rst_r8", rd_data[63:32], 0);
    wa_en = 1; wa_addr = 8; wa_data = 32'h12345678; rd_addr = {5'd0, 5'd8};
    #1 check("byp_a_r8", rd_data[31:0], 32'h12345678);
    tick(); idle();
    #1 check("store_r8", rd_data[31:0], 32'h12345678);
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0};
    #1 check("r0_byp", rd_data[31:0], 0);
    tick(); idle();
    #1 check("r0_store", rd_data[63:32], 0);
    wa_en = 1; wa_link = 1; wa_addr = 5; wa_data = 32'h00003004;
    tick(); idle();
    rd_addr = {5'd5, 5'd31};
    #1 check("link_r31", rd_data[31:0], 32'h00003004);
    check("link_r5", rd_data[63:32], 0);
    iss_en = 1; iss_addr = 9; rd_addr = {5'd9, 5'd9};
    #1 check("iss_same_busy", rd_busy, 2'b00);
    tick(); idle();
    #1 check("busy9", busy_vec[9], 1);
    check("rdbusy9", rd_busy, 2'b11);
    wb_en = 1; wb_addr = 9; wb_data = 32'hCAFE;
    #1 check("wb_unstall", rd_busy, 2'b00);
    check("wb_byp", rd_data[31:0], 32'hCAFE);
    tick(); idle();
    #1 check("busy9_clr", busy_vec[9], 0);
    check("wb_store", rd_data[63:32], 32'hCAFE);
    iss_en = 1; iss_addr = 10; wb_en = 1; wb_addr = 10; wb_data = 32'h10;
    tick(); idle();
    rd_addr = {5'd0, 5'd10};
    #1 check("set_wins", busy_vec[10], 1);
    check("r10_data", rd_data[31:0], 32'h10);
    check("r10_busy", rd_busy, 2'b01);
    iss_en = 1; iss_addr = 12;
    tick(); idle();
    wa_en = 1; wa_addr = 12; wa_data = 1; wb_en = 1; wb_addr = 12; wb_data = 2; rd_addr = {5'd12, 5'd12};
    #1 check("conf_byp", rd_data, {32'h1, 32'h1});
    check("conf_pre", wr_conflict, 0);
    tick(); idle();
    #1 check("conf_pulse", wr_conflict, 1);
    check("conf_r12", rd_data[31:0], 1);
    check("conf_busy", busy_vec[12], 0);
    tick();
    check("conf_drop", wr_conflict, 0);
    iss_en = 1; iss_addr = 3;
    tick();
    iss_addr = 4;
    tick(); idle();
    #1 check("busy34", busy_vec[4:3], 2'b11);
    reset = 1; wa_en = 1; wa_addr = 3; wa_data = 32'hDEAD;
    tick(); idle();
    rd_addr = {5'd8, 5'd3};
    #1 check("rst2_busy", busy_vec, 0);
    check("rst2_r3", rd_data[31:0], 0);
    check("rst2_r8", rd_data[63:32], 0);
    wb_en = 1; wb_addr = 3; wb_data = 32'h77;
    tick(); idle();
    #1 check("post_rst_wb", rd_data[31:0], 32'h77);
    check("post_rst_busy", busy_vec, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
